// File: rtl/register_em_skid_if.sv
// Execute->Memory handshake bundle: E-side offer in, M-side beat out.
// slave is the pipeline register's view; master is the surrounding stages' view.
interface register_em_skid_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned RD_W = 5;
    localparam int unsigned RS_W = 2;

    // Execute side
    logic            valid_e;
    logic            ready_e;
    logic            RegWriteE;
    logic [RS_W-1:0] ResultSrcE;
    logic            MemWriteE;
    logic [XLEN-1:0] ALUResultE;
    logic [XLEN-1:0] WriteDataE;
    logic [XLEN-1:0] PCPlus4E;
    logic [RD_W-1:0] RdE;

    // Memory side
    logic            valid_m;
    logic            ready_m;
    logic            RegWriteM;
    logic [RS_W-1:0] ResultSrcM;
    logic            MemWriteM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [RD_W-1:0] RdM;

    modport slave (
        input  valid_e, RegWriteE, ResultSrcE, MemWriteE,
               ALUResultE, WriteDataE, PCPlus4E, RdE,
        output ready_e,
        output valid_m, RegWriteM, ResultSrcM, MemWriteM,
               ALUResultM, WriteDataM, PCPlus4M, RdM,
        input  ready_m
    );

    modport master (
        output valid_e, RegWriteE, ResultSrcE, MemWriteE,
               ALUResultE, WriteDataE, PCPlus4E, RdE,
        input  ready_e,
        input  valid_m, RegWriteM, ResultSrcM, MemWriteM,
               ALUResultM, WriteDataM, PCPlus4M, RdM,
        output ready_m
    );
endinterface

// File: rtl/register_em_skid.sv
// Execute->Memory pipeline register with a one-entry skid buffer.
// ready_e comes straight from a flop, so there is no combinational path from ready_m.
// Optional feature macro: EM_STALL_CNT_EN adds the saturating stall_cnt output.
module register_em_skid #(
    parameter int unsigned XLEN  = 32
`ifdef EM_STALL_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_m,
    register_em_skid_if.slave     bus
`ifdef EM_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);
    localparam int unsigned RD_W = 5;
    localparam int unsigned RS_W = 2;

    typedef struct packed {
        logic            reg_write;
        logic [RS_W-1:0] result_src;
        logic            mem_write;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [RD_W-1:0] rd;
    } payload_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t   r_state;
    payload_t r_main;
    payload_t r_skid;
    logic     r_valid_m;
    logic     r_ready_e;

    payload_t w_e_beat;
    logic     w_acc;
    logic     w_drn;

    // Gather the E-side fields into one beat
    assign w_e_beat = '{
        reg_write:  bus.RegWriteE,
        result_src: bus.ResultSrcE,
        mem_write:  bus.MemWriteE,
        alu_result: bus.ALUResultE,
        write_data: bus.WriteDataE,
        pc_plus4:   bus.PCPlus4E,
        rd:         bus.RdE
    };

    assign w_acc = bus.valid_e & r_ready_e;
    assign w_drn = r_valid_m & bus.ready_m;

    // Control FSM with registered valid_m/ready_e; main entry feeds the M side
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            r_valid_m <= 1'b0;
            r_ready_e <= 1'b1;
            r_main    <= '0;
            r_skid    <= '0;
        end else if (flush_m) begin
            // Wrong-path squash: control fields cleared, data fields left as-is
            r_state           <= S_EMPTY;
            r_valid_m         <= 1'b0;
            r_ready_e         <= 1'b1;
            r_main.reg_write  <= 1'b0;
            r_main.mem_write  <= 1'b0;
            r_main.result_src <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_main    <= w_e_beat;
                        r_valid_m <= 1'b1;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_acc && w_drn) begin
                        r_main <= w_e_beat;
                    end else if (w_acc) begin
                        r_skid    <= w_e_beat;
                        r_ready_e <= 1'b0;
                        r_state   <= S_FULL;
                    end else if (w_drn) begin
                        r_valid_m <= 1'b0;
                        r_state   <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_drn) begin
                        r_main    <= r_skid;
                        r_ready_e <= 1'b1;
                        r_state   <= S_BUSY;
                    end
                end
                default: begin
                    r_state   <= S_EMPTY;
                    r_valid_m <= 1'b0;
                    r_ready_e <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_e    = r_ready_e;
    assign bus.valid_m    = r_valid_m;
    assign bus.RegWriteM  = r_main.reg_write;
    assign bus.ResultSrcM = r_main.result_src;
    assign bus.MemWriteM  = r_main.mem_write;
    assign bus.ALUResultM = r_main.alu_result;
    assign bus.WriteDataM = r_main.write_data;
    assign bus.PCPlus4M   = r_main.pc_plus4;
    assign bus.RdM        = r_main.rd;

`ifdef EM_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Count cycles the memory stage holds off a presented beat; saturates, survives flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_valid_m && !bus.ready_m && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_register_em_skid.sv
// Bench for register_em_skid: directed vector table, random streaming with flushes,
// and an occupancy/ordering scoreboard fed from the accepted E-side beats.
module tb_register_em_skid;
    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  rd;
    } pl_t;

    typedef struct packed {
        logic        r;
        logic        f;
        logic        v;
        logic        m;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        evm;
        logic        ere;
        logic        ectl;
    } vec_t;

    logic clk;
    logic rst;
    logic flush_m;
    int   n_cmp;
    int   n_bad;
    pl_t  q[$];
    pl_t  prev_m;
    logic prev_hold;
    vec_t tbl [0:31];

    register_em_skid_if #(.XLEN(32)) bus ();

`ifdef EM_STALL_CNT_EN
    logic [2:0] stall_cnt;
    register_em_skid #(.XLEN(32), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_m   (flush_m),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );
`else
    register_em_skid #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_m (flush_m),
        .bus     (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pl_t mk(input logic [4:0] rd, input logic [31:0] alu);
        pl_t p;
        p.rw  = ~rd[4];
        p.rs  = rd[2:1];
        p.mw  = rd[0];
        p.alu = alu;
        p.wd  = alu ^ 32'hA5A5_5A5A;
        p.pc  = 32'h0000_1000 + {25'd0, rd, 2'b00};
        p.rd  = rd;
        return p;
    endfunction

    function automatic pl_t get_m();
        pl_t p;
        p.rw  = bus.RegWriteM;
        p.rs  = bus.ResultSrcM;
        p.mw  = bus.MemWriteM;
        p.alu = bus.ALUResultM;
        p.wd  = bus.WriteDataM;
        p.pc  = bus.PCPlus4M;
        p.rd  = bus.RdM;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic m,
                         input logic [4:0] rd, input logic [31:0] alu);
        pl_t p;
        p              = mk(rd, alu);
        rst            = r;
        flush_m        = f;
        bus.valid_e    = v;
        bus.ready_m    = m;
        bus.RegWriteE  = p.rw;
        bus.ResultSrcE = p.rs;
        bus.MemWriteE  = p.mw;
        bus.ALUResultE = p.alu;
        bus.WriteDataE = p.wd;
        bus.PCPlus4E   = p.pc;
        bus.RdE        = p.rd;
    endtask

    // Runs at the negedge: occupancy checks, ordered pop on drain, push on accept
    task automatic sb_update();
        pl_t cur;
        pl_t exp;
        pl_t inb;
        logic acc;
        logic drn;
        cur = get_m();
        inb = mk(bus.RdE, bus.ALUResultE);
        acc = bus.valid_e & bus.ready_e;
        drn = bus.valid_m & bus.ready_m;
        chk("occ_valid_m", 128'(bus.valid_m), 128'(q.size() != 0));
        chk("occ_ready_e", 128'(bus.ready_e), 128'(q.size() < 2));
        if (prev_hold) chk("hold_stable", 128'(cur), 128'(prev_m));
        if (rst) begin
            q.delete();
            prev_hold = 1'b0;
        end else begin
            if (drn) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 128'(cur), 128'(0));
                end else begin
                    exp = q.pop_front();
                    chk("beat_order", 128'(cur), 128'(exp));
                end
            end
            if (flush_m) q.delete();
            else if (acc) q.push_back(inb);
            prev_hold = !flush_m && bus.valid_m && !bus.ready_m;
            prev_m    = cur;
        end
    endtask

    task automatic finish_cycle();
        sb_update();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    initial begin
        int guard;
        n_cmp     = 0;
        n_bad     = 0;
        prev_hold = 1'b0;
        prev_m    = '0;

        // r f v m | rd | alu | visible valid_m, ready_e, control-cleared
        tbl[0]  = {4'b1010, 5'd9,  32'h90, 3'b010};
        tbl[1]  = {4'b1010, 5'd9,  32'h90, 3'b011};
        tbl[2]  = {4'b0000, 5'd0,  32'h00, 3'b011};
        tbl[3]  = {4'b0011, 5'd1,  32'h10, 3'b010};
        tbl[4]  = {4'b0011, 5'd2,  32'h20, 3'b110};
        tbl[5]  = {4'b0001, 5'd0,  32'h00, 3'b110};
        tbl[6]  = {4'b0000, 5'd0,  32'h00, 3'b010};
        tbl[7]  = {4'b0010, 5'd3,  32'h30, 3'b010};
        tbl[8]  = {4'b0010, 5'd4,  32'h40, 3'b110};
        tbl[9]  = {4'b0010, 5'd5,  32'h50, 3'b100};
        tbl[10] = {4'b0010, 5'd5,  32'h50, 3'b100};
        tbl[11] = {4'b0011, 5'd5,  32'h50, 3'b100};
        tbl[12] = {4'b0011, 5'd5,  32'h50, 3'b110};
        tbl[13] = {4'b0001, 5'd0,  32'h00, 3'b110};
        tbl[14] = {4'b0000, 5'd0,  32'h00, 3'b010};
        tbl[15] = {4'b0010, 5'd6,  32'h60, 3'b010};
        tbl[16] = {4'b0010, 5'd7,  32'h70, 3'b110};
        tbl[17] = {4'b0110, 5'd8,  32'h80, 3'b100};
        tbl[18] = {4'b0000, 5'd0,  32'h00, 3'b011};
        tbl[19] = {4'b0001, 5'd0,  32'h00, 3'b010};
        tbl[20] = {4'b0010, 5'd9,  32'h99, 3'b010};
        tbl[21] = {4'b0101, 5'd0,  32'h00, 3'b110};
        tbl[22] = {4'b0001, 5'd0,  32'h00, 3'b011};
        tbl[23] = {4'b0010, 5'd10, 32'hA0, 3'b010};
        tbl[24] = {4'b0010, 5'd11, 32'hB0, 3'b110};
        tbl[25] = {4'b0111, 5'd12, 32'hC0, 3'b100};
        tbl[26] = {4'b0001, 5'd0,  32'h00, 3'b011};
        tbl[27] = {4'b0010, 5'd13, 32'hD0, 3'b010};
        tbl[28] = {4'b0010, 5'd14, 32'hE0, 3'b110};
        tbl[29] = {4'b1010, 5'd15, 32'hF0, 3'b100};
        tbl[30] = {4'b0001, 5'd0,  32'h00, 3'b011};
        tbl[31] = {4'b0000, 5'd0,  32'h00, 3'b010};

        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h90);
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].m, tbl[i].rd, tbl[i].alu);
            @(negedge clk);
            chk($sformatf("row%0d_valid_m", i), 128'(bus.valid_m), 128'(tbl[i].evm));
            chk($sformatf("row%0d_ready_e", i), 128'(bus.ready_e), 128'(tbl[i].ere));
            if (tbl[i].ectl)
                chk($sformatf("row%0d_ctl_clear", i),
                    128'({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM}), 128'(0));
            finish_cycle();
        end

        // Random streaming with back-pressure and occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(1'b0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
            tick();
        end

        // Drain whatever is still held, bounded
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            tick();
            guard++;
        end
        tick();
        chk("drain_done", 128'(q.size()), 128'(0));

`ifdef EM_STALL_CNT_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h33);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (5) tick();
        @(negedge clk);
        chk("stall_cnt_5", 128'(stall_cnt), 128'(5));
        finish_cycle();
        repeat (3) tick();
        @(negedge clk);
        chk("stall_cnt_sat", 128'(stall_cnt), 128'(7));
        finish_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("stall_cnt_flush", 128'(stall_cnt), 128'(7));
        finish_cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
